// File: rtl/sampler.sv
// sampler: captures one left/right frame per codec period from two Avalon-ST
// sinks and writes it as one 16-bit word into a circular input buffer. The
// buffer is split into four equal windows; go_out pulses as each one fills.
//
// Ports:
//   clk, reset (async, active-high)   - clock and reset
//   run                               - capture enable (sampled in IDLE/WRITE)
//   left_in_*/right_in_*              - from_adc sinks (data/valid/ready)
//   in_buf_addr/in_buf_data/wren      - input buffer write port
//   window_start/go_out               - completed window index + 1-cycle pulse
//
// Optional feature macro: SAMPLER_MONO_MIX_EN
//   defined   : sample = floor((L + R) / 2)
//   undefined : sample = L; R is still handshaken and then dropped

module sampler #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [15:0]       left_in_data,
  input  logic              left_in_valid,
  output logic              left_in_ready,
  input  logic [15:0]       right_in_data,
  input  logic              right_in_valid,
  output logic              right_in_ready,
  output logic [ADDR_W-1:0] in_buf_addr,
  output logic [15:0]       in_buf_data,
  output logic              in_buf_wren,
  output logic [1:0]        window_start,
  output logic              go_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    WRITE   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                have_l_q, have_l_d;
  logic                have_r_q, have_r_d;
  logic [15:0]         left_q, left_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [1:0]          win_q, win_d;
  logic                go_q, go_d;

`ifdef SAMPLER_MONO_MIX_EN
  logic [15:0]         right_q, right_d;
  logic signed [16:0]  mix_sum;

  // 17-bit sum cannot overflow; the arithmetic shift floors toward -inf.
  assign mix_sum     = $signed({left_q[15], left_q}) + $signed({right_q[15], right_q});
  assign in_buf_data = 16'(mix_sum >>> 1);
`else
  // Right channel is accepted only to keep the codec FIFOs draining evenly.
  logic                unused_right;
  assign unused_right = ^right_in_data;
  assign in_buf_data  = left_q;
`endif

  // A channel that already holds its sample for this frame stalls its source.
  assign left_in_ready  = (state_q == CAPTURE) && !have_l_q;
  assign right_in_ready = (state_q == CAPTURE) && !have_r_q;
  assign in_buf_wren    = (state_q == WRITE);
  assign in_buf_addr    = ptr_q;
  assign window_start   = win_q;
  assign go_out         = go_q;

  always_comb begin
    state_d  = state_q;
    have_l_d = have_l_q;
    have_r_d = have_r_q;
    left_d   = left_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    go_d     = 1'b0;
`ifdef SAMPLER_MONO_MIX_EN
    right_d  = right_q;
`endif
    case (state_q)
      IDLE: begin
        if (run) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (left_in_valid && left_in_ready) begin
          have_l_d = 1'b1;
          left_d   = left_in_data;
        end
        if (right_in_valid && right_in_ready) begin
          have_r_d = 1'b1;
`ifdef SAMPLER_MONO_MIX_EN
          right_d  = right_in_data;
`endif
        end
        // Looks at the next-flag values so a same-cycle completion counts.
        if (have_l_d && have_r_d) state_d = WRITE;
      end
      WRITE: begin
        have_l_d = 1'b0;
        have_r_d = 1'b0;
        ptr_d    = ptr_q + ADDR_W'(1);
        // Last slot of a window just written: announce that window.
        if (&ptr_q[ADDR_W-3:0]) begin
          go_d  = 1'b1;
          win_d = ptr_q[ADDR_W-1:ADDR_W-2];
        end
        state_d = run ? CAPTURE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      have_l_q <= 1'b0;
      have_r_q <= 1'b0;
      left_q   <= '0;
      ptr_q    <= '0;
      win_q    <= '0;
      go_q     <= 1'b0;
`ifdef SAMPLER_MONO_MIX_EN
      right_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      have_l_q <= have_l_d;
      have_r_q <= have_r_d;
      left_q   <= left_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      go_q     <= go_d;
`ifdef SAMPLER_MONO_MIX_EN
      right_q  <= right_d;
`endif
    end
  end

endmodule

// File: tb/tb_sampler.sv
// Testbench for sampler (ADDR_W = 4): reset, latency, staggered handshakes,
// sample arithmetic, window/wrap sequencing, run deassertion and mid-frame reset.
module tb_sampler;

  localparam int AW = 4;
`ifdef SAMPLER_MONO_MIX_EN
  localparam bit MONO = 1'b1;
`else
  localparam bit MONO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          run;
  logic [15:0]   ld, rd;
  logic          lv, rv;
  logic          left_in_ready, right_in_ready;
  logic [AW-1:0] in_buf_addr;
  logic [15:0]   in_buf_data;
  logic          in_buf_wren;
  logic [1:0]    window_start;
  logic          go_out;

  sampler #(.ADDR_W(AW)) dut (
    .clk            (clk),
    .reset          (reset),
    .run            (run),
    .left_in_data   (ld),
    .left_in_valid  (lv),
    .left_in_ready  (left_in_ready),
    .right_in_data  (rd),
    .right_in_valid (rv),
    .right_in_ready (right_in_ready),
    .in_buf_addr    (in_buf_addr),
    .in_buf_data    (in_buf_data),
    .in_buf_wren    (in_buf_wren),
    .window_start   (window_start),
    .go_out         (go_out)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int exp_ptr = 0;
  int wr_cnt = 0;

  always @(negedge clk) if (in_buf_wren === 1'b1) wr_cnt++;

  // Reference sample: plain integer average rounded toward -inf, or left only.
  function automatic logic [15:0] model_sample(input logic [15:0] l, input logic [15:0] r);
    int s;
    if (MONO) begin
      s = int'($signed(l)) + int'($signed(r));
      s = (s < 0 && (s % 2 != 0)) ? (s - 1) / 2 : s / 2;
      return s[15:0];
    end
    return l;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents one frame on both channels and returns what the buffer port and
  // the window outputs showed one and two cycles after the last transfer.
  task automatic send_frame(input logic [15:0] l, input logic [15:0] r,
                            output bit ok, output logic w, output logic [AW-1:0] a,
                            output logic [15:0] d, output logic g, output logic [1:0] ws);
    bit la, ra;
    ok = 1'b0;
    ld = l; rd = r; lv = 1'b1; rv = 1'b1;
    for (int i = 0; i < 40; i++) begin
      la = lv && left_in_ready;
      ra = rv && right_in_ready;
      tick();
      if (la) lv = 1'b0;
      if (ra) rv = 1'b0;
      if (!lv && !rv) begin ok = 1'b1; break; end
    end
    lv = 1'b0; rv = 1'b0;
    w = in_buf_wren; a = in_buf_addr; d = in_buf_data;
    tick();
    g = go_out; ws = window_start;
  endtask

  task automatic test_reset;
    reset = 1'b1; run = 1'b0; lv = 1'b0; rv = 1'b0; ld = '0; rd = '0;
    repeat (2) tick();
    tests++; if ({left_in_ready, right_in_ready} !== 2'b00) begin fails++; $display("FAIL reset_ready got=%b want=00", {left_in_ready, right_in_ready}); end
    tests++; if (in_buf_wren !== 1'b0) begin fails++; $display("FAIL reset_wren got=%b want=0", in_buf_wren); end
    tests++; if (in_buf_addr !== '0) begin fails++; $display("FAIL reset_addr got=%h want=0", in_buf_addr); end
    tests++; if (in_buf_data !== 16'h0) begin fails++; $display("FAIL reset_data got=%h want=0", in_buf_data); end
    tests++; if ({window_start, go_out} !== 3'b000) begin fails++; $display("FAIL reset_window got=%b want=000", {window_start, go_out}); end
    reset = 1'b0;
    lv = 1'b1; rv = 1'b1;
    repeat (3) tick();
    tests++; if ({left_in_ready, right_in_ready, in_buf_wren} !== 3'b000) begin fails++; $display("FAIL idle_no_run got=%b want=000", {left_in_ready, right_in_ready, in_buf_wren}); end
    lv = 1'b0; rv = 1'b0;
    exp_ptr = 0;
  endtask

  task automatic test_first_frame;
    logic [15:0] exp_d;
    exp_d = MONO ? 16'h091A : 16'h1234;
    run = 1'b1;
    tick();
    tests++; if ({left_in_ready, right_in_ready} !== 2'b11) begin fails++; $display("FAIL capture_ready got=%b want=11", {left_in_ready, right_in_ready}); end
    ld = 16'h1234; rd = 16'h0000; lv = 1'b1; rv = 1'b1;
    tick();
    lv = 1'b0; rv = 1'b0;
    tests++; if (in_buf_wren !== 1'b1) begin fails++; $display("FAIL first_wren got=%b want=1", in_buf_wren); end
    tests++; if (in_buf_addr !== 4'd0) begin fails++; $display("FAIL first_addr got=%h want=0", in_buf_addr); end
    tests++; if (in_buf_data !== exp_d) begin fails++; $display("FAIL first_data got=%h want=%h", in_buf_data, exp_d); end
    tests++; if ({left_in_ready, right_in_ready} !== 2'b00) begin fails++; $display("FAIL write_ready got=%b want=00", {left_in_ready, right_in_ready}); end
    tick();
    tests++; if ({left_in_ready, right_in_ready, in_buf_wren, go_out} !== 4'b1100) begin fails++; $display("FAIL first_after got=%b want=1100", {left_in_ready, right_in_ready, in_buf_wren, go_out}); end
    exp_ptr = 1;
  endtask

  task automatic test_staggered;
    logic [15:0] l1, l2, r1, r2;
    int c0;
    l1 = 16'($urandom); l2 = ~l1; r1 = 16'($urandom); r2 = 16'($urandom);
    c0 = wr_cnt;
    ld = l1; lv = 1'b1;
    tick();
    ld = l2;
    for (int k = 0; k < 4; k++) begin
      tests++; if (left_in_ready !== 1'b0) begin fails++; $display("FAIL stagger_lready k=%0d got=%b want=0", k, left_in_ready); end
      if (k == 3) begin rd = r1; rv = 1'b1; end
      tick();
    end
    rv = 1'b0;
    tests++; if (wr_cnt !== c0) begin fails++; $display("FAIL stagger_early_write got=%0d want=%0d", wr_cnt - c0, 0); end
    tests++; if (in_buf_wren !== 1'b1) begin fails++; $display("FAIL stagger_wren got=%b want=1", in_buf_wren); end
    tests++; if (in_buf_addr !== AW'(exp_ptr)) begin fails++; $display("FAIL stagger_addr got=%h want=%h", in_buf_addr, AW'(exp_ptr)); end
    tests++; if (in_buf_data !== model_sample(l1, r1)) begin fails++; $display("FAIL stagger_data got=%h want=%h", in_buf_data, model_sample(l1, r1)); end
    exp_ptr++;
    tick();
    rd = r2; rv = 1'b1;
    tick();
    lv = 1'b0; rv = 1'b0;
    tests++; if (wr_cnt !== c0 + 1) begin fails++; $display("FAIL stagger_write_count got=%0d want=1", wr_cnt - c0); end
    tests++; if (in_buf_data !== model_sample(l2, r2) || in_buf_wren !== 1'b1) begin fails++; $display("FAIL stagger_held_sample got=%h/%b want=%h/1", in_buf_data, in_buf_wren, model_sample(l2, r2)); end
    exp_ptr++;
    tick();
  endtask

  task automatic test_mix;
    logic [15:0] tl[3], tr[3], te[3];
    bit ok; logic w, g; logic [AW-1:0] a; logic [15:0] d; logic [1:0] ws;
`ifdef SAMPLER_MONO_MIX_EN
    tl = '{16'h7FFF, 16'h8000, 16'hFFFF};
    tr = '{16'h7FFF, 16'h8000, 16'h0000};
    te = '{16'h7FFF, 16'h8000, 16'hFFFF};
`else
    for (int i = 0; i < 3; i++) begin
      tl[i] = 16'($urandom); tr[i] = 16'($urandom); te[i] = tl[i];
    end
`endif
    for (int i = 0; i < 3; i++) begin
      send_frame(tl[i], tr[i], ok, w, a, d, g, ws);
      tests++; if (!ok || w !== 1'b1) begin fails++; $display("FAIL mix_write i=%0d got=%b want=1", i, w); end
      tests++; if (a !== AW'(exp_ptr)) begin fails++; $display("FAIL mix_addr i=%0d got=%h want=%h", i, a, AW'(exp_ptr)); end
      tests++; if (d !== te[i]) begin fails++; $display("FAIL mix_data i=%0d got=%h want=%h", i, d, te[i]); end
      tests++; if (g !== ((exp_ptr % 4) == 3)) begin fails++; $display("FAIL mix_go i=%0d got=%b want=%b", i, g, (exp_ptr % 4) == 3); end
      exp_ptr++;
    end
  endtask

  task automatic test_wrap;
    bit ok; logic w, g; logic [AW-1:0] a; logic [15:0] d; logic [1:0] ws;
    logic [15:0] l, r;
    int exp_win, gos;
    bit eg;
    reset = 1'b1; tick(); reset = 1'b0; run = 1'b1; tick();
    exp_ptr = 0; exp_win = 0; gos = 0;
    for (int f = 0; f < 20; f++) begin
      l = 16'($urandom); r = 16'($urandom);
      send_frame(l, r, ok, w, a, d, g, ws);
      eg = ((f % 16) % 4) == 3;
      if (eg) begin exp_win = (f % 16) / 4; gos++; end
      tests++; if (!ok || w !== 1'b1) begin fails++; $display("FAIL wrap_write f=%0d got=%b want=1", f, w); end
      tests++; if (a !== AW'(f % 16)) begin fails++; $display("FAIL wrap_addr f=%0d got=%h want=%h", f, a, AW'(f % 16)); end
      tests++; if (d !== model_sample(l, r)) begin fails++; $display("FAIL wrap_data f=%0d got=%h want=%h", f, d, model_sample(l, r)); end
      tests++; if (g !== eg) begin fails++; $display("FAIL wrap_go f=%0d got=%b want=%b", f, g, eg); end
      tests++; if (ws !== 2'(exp_win)) begin fails++; $display("FAIL wrap_window f=%0d got=%0d want=%0d", f, ws, exp_win); end
      if (eg) begin
        tick();
        tests++; if (go_out !== 1'b0) begin fails++; $display("FAIL wrap_go_width f=%0d got=%b want=0", f, go_out); end
      end
    end
    tests++; if (gos !== 5) begin fails++; $display("FAIL wrap_go_count got=%0d want=5", gos); end
    exp_ptr = 20;
  endtask

  task automatic test_run_drop;
    bit ok; logic w, g; logic [AW-1:0] a; logic [15:0] d; logic [1:0] ws;
    logic [15:0] l, r;
    int c0;
    l = 16'($urandom); r = 16'($urandom);
    ld = l; lv = 1'b1;
    tick();
    lv = 1'b0; run = 1'b0;
    repeat (2) tick();
    tests++; if ({left_in_ready, right_in_ready} !== 2'b01) begin fails++; $display("FAIL drop_midframe_ready got=%b want=01", {left_in_ready, right_in_ready}); end
    rd = r; rv = 1'b1;
    tick();
    rv = 1'b0;
    tests++; if (in_buf_wren !== 1'b1 || in_buf_addr !== AW'(exp_ptr)) begin fails++; $display("FAIL drop_write got=%b@%h want=1@%h", in_buf_wren, in_buf_addr, AW'(exp_ptr)); end
    tests++; if (in_buf_data !== model_sample(l, r)) begin fails++; $display("FAIL drop_data got=%h want=%h", in_buf_data, model_sample(l, r)); end
    exp_ptr++;
    tick();
    c0 = wr_cnt;
    lv = 1'b1; rv = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tests++; if ({left_in_ready, right_in_ready} !== 2'b00) begin fails++; $display("FAIL drop_idle_ready k=%0d got=%b want=00", k, {left_in_ready, right_in_ready}); end
      tick();
    end
    lv = 1'b0; rv = 1'b0;
    tests++; if (wr_cnt !== c0) begin fails++; $display("FAIL drop_idle_writes got=%0d want=0", wr_cnt - c0); end
    run = 1'b1;
    l = 16'($urandom); r = 16'($urandom);
    send_frame(l, r, ok, w, a, d, g, ws);
    tests++; if (!ok || w !== 1'b1 || a !== AW'(exp_ptr % 16)) begin fails++; $display("FAIL drop_resume got=%b@%h want=1@%h", w, a, AW'(exp_ptr % 16)); end
    exp_ptr++;
  endtask

  task automatic test_reset_mid;
    bit ok; logic w, g; logic [AW-1:0] a; logic [15:0] d; logic [1:0] ws;
    ld = 16'($urandom) | 16'h0001; lv = 1'b1;
    tick();
    lv = 1'b0;
    tests++; if ({left_in_ready, right_in_ready} !== 2'b01) begin fails++; $display("FAIL rmid_latched got=%b want=01", {left_in_ready, right_in_ready}); end
    reset = 1'b1;
    #1;
    tests++; if ({left_in_ready, right_in_ready, in_buf_wren, go_out} !== 4'b0000) begin fails++; $display("FAIL rmid_ctrl got=%b want=0000", {left_in_ready, right_in_ready, in_buf_wren, go_out}); end
    tests++; if (in_buf_addr !== '0 || in_buf_data !== 16'h0 || window_start !== 2'd0) begin fails++; $display("FAIL rmid_data got=%h/%h/%0d want=0/0/0", in_buf_addr, in_buf_data, window_start); end
    tick();
    reset = 1'b0;
    tick();
    send_frame(16'($urandom), 16'($urandom), ok, w, a, d, g, ws);
    tests++; if (!ok || w !== 1'b1 || a !== '0) begin fails++; $display("FAIL rmid_addr got=%b@%h want=1@0", w, a); end
    tests++; if (g !== 1'b0 || ws !== 2'd0) begin fails++; $display("FAIL rmid_go got=%b/%0d want=0/0", g, ws); end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_staggered();
    test_mix();
    test_wrap();
    test_run_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sampler.md
# sampler

Avalon-ST sink pair that collects one sample per frame from the Wolfson audio CODEC's from_adc left and right channel sources. It writes each frame as one 16-bit word into a circular input buffer RAM. The buffer is split into four equal windows. Each time a window fills, the block pulses `go_out` with its index, so the windowing/pitch-shift pipeline can start on fresh audio. It is the capture-side counterpart of the emitter that drives the to_dac sinks.

## Interface
Parameters:
- `ADDR_W`, default 10: input buffer address width; the buffer holds 2^ADDR_W samples in 4 windows of 2^(ADDR_W-2) samples each.

Ports:
- `clk` in 1: sole clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `run` in 1: capture enable from the control register.
- `left_in_data` in 16: from_adc left channel sample, signed two's complement.
- `left_in_valid` in 1: left source valid.
- `left_in_ready` out 1: left sink ready.
- `right_in_data` in 16: from_adc right channel sample, signed.
- `right_in_valid` in 1: right source valid.
- `right_in_ready` out 1: right sink ready.
- `in_buf_addr` out ADDR_W: input buffer write address.
- `in_buf_data` out 16: input buffer write data.
- `in_buf_wren` out 1: input buffer write enable.
- `window_start` out 2: index of the most recently completed window.
- `go_out` out 1: one-cycle pulse when a window completes.

## Operation
- FSM states: IDLE, CAPTURE, WRITE.
- IDLE:
  - Both readys are 0.
  - Moves to CAPTURE when `run` = 1.
- CAPTURE:
  - Each channel has its own "have" flag.
  - `x_in_ready` = 1 while that channel's flag is 0.
  - A transfer occurs when valid && ready. On transfer, the data is latched and the flag is set.
  - The two channels may transfer on different cycles, in either order, or on the same cycle.
  - Once both flags are set (including on the transfer cycle itself), the FSM moves to WRITE.
  - A channel whose flag is set holds ready at 0. Its extra valid data is not consumed.
- WRITE:
  - `in_buf_wren` = 1 for exactly one cycle.
  - `in_buf_data` = the frame sample; `in_buf_addr` = the current write pointer.
  - Both flags are cleared and the pointer increments modulo 2^ADDR_W.
  - If the written address had all low ADDR_W-2 bits equal to 1, the window is complete: `window_start` <= addr[ADDR_W-1:ADDR_W-2] and `go_out` pulses on the next cycle.
  - Next state is CAPTURE if `run` = 1, else IDLE.
- `run` is sampled only in IDLE and WRITE. Deasserting `run` mid-frame finishes the current frame first.
- The pointer is not reset by `run`; capture resumes at the next address.
- Wrap-around:
  - Address 2^ADDR_W-1 is followed by address 0.
  - `window_start` goes 0, 1, 2, 3, 0, …
- Overrun is not detected; the downstream consumer must finish a window within 3 window periods.

## Timing
- Reset values:
  - Every output is 0: readys, `in_buf_addr`, `in_buf_data`, `in_buf_wren`, `window_start`, `go_out`.
  - FSM is in IDLE; pointer and flags are 0.
- Reset asserted mid-operation discards any partial frame and any pending `go_out`.
- Latency, with the later channel transfer at cycle N:
  - Write at cycle N+1.
  - `go_out` at cycle N+2, if applicable.
  - Readys high again at N+2 (state is CAPTURE at N+2).
- Minimum frame period is 2 cycles, far below the codec rate.
- `window_start` changes on the same edge that raises `go_out` and is held until the next window completes.

## Configuration
- `SAMPLER_MONO_MIX_EN` defined:
  - Sample = (sext17(L) + sext17(R)) >>> 1, truncated to 16 bits.
  - This is an arithmetic floor; saturation is impossible.
- Not defined:
  - Sample = L.
  - The right channel is still accepted through the same handshake and then discarded, so both codec FIFOs drain equally.

## Test plan
- Reset, then `run` = 1 and one frame of L = 0x1234, R = 0x0000 presented on the same cycle N. Required:
  - Write at N+1 to address 0.
  - Data = 0x091A with the macro, 0x1234 without.
  - Readys high at N+2.
- Staggered arrival: L valid at cycle 5, R valid at cycle 9. Required:
  - `left_in_ready` low during cycles 6–9.
  - Single write at cycle 10.
  - A second left sample held during cycles 6–9 is not consumed.
- Mono arithmetic (macro on):
  - (0x7FFF, 0x7FFF) -> 0x7FFF.
  - (0x8000, 0x8000) -> 0x8000.
  - (0xFFFF, 0x0000) -> 0xFFFF.
- ADDR_W = 4, stream 20 frames. Required:
  - `go_out` pulses after addresses 3, 7, 11, 15 and 3, with `window_start` = 0, 1, 2, 3, 0 respectively.
  - The address wraps 15 -> 0.
- `run` dropped after L accepted but before R. Required:
  - The frame completes once R arrives and the write occurs.
  - State is IDLE afterwards with readys 0.
  - Raising `run` later resumes at the next address.
- `reset` pulsed while state is CAPTURE with L latched. Required:
  - All outputs 0 immediately.
  - The next frame after reset is written to address 0 and no `go_out` is emitted.
